johnson_decoder: RTL and testbench

- Receive end of the Johnson counter chain: samples a 2N-state Johnson code each valid cycle.
- Decodes the code to a binary count and a one-hot phase.
- Checks legality and sequence continuity (each code must be the ring successor of the previous one).
- Sits beside counter-driven sequencers and flags corrupted or skipped counter states to a monitor.

---
 rtl/johnson_pkg.sv | 16 +
 rtl/johnson_code_check.sv | 35 +++
 rtl/johnson_decoder.sv | 140 ++++++++++++++
 tb/tb_johnson_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code receive path.
// Used by johnson_code_check and johnson_decoder.
package johnson_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        TRACK  = 1'b1
    } state_e;

    localparam int LOCK_W = 4;

    function automatic int cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson-code classifier: code -> {legal, count 0..2N-1}.
// Reusable by any Johnson-counter consumer; illegal codes report count 0.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = cnt_w(N)
) (
    input  logic [N-1:0]  code_i,
    output logic          legal_o,
    output logic [CW-1:0] count_o
);

    logic [N-1:0]  inv_s;
    logic [CW-1:0] ones_s;
    logic          contig_s;

    // Fold the upper half of the ring onto the lower half, then demand a run of ones from bit 0.
    always_comb begin
        inv_s    = code_i[N-1] ? ~code_i : code_i;
        ones_s   = '0;
        for (int i = 0; i < N; i++) begin
            ones_s = ones_s + CW'(inv_s[i]);
        end
        contig_s = ((inv_s & (inv_s + N'(1))) == N'(0));
        if (contig_s) begin
            legal_o = 1'b1;
            count_o = code_i[N-1] ? (CW'(N) + ones_s) : ones_s;
        end else begin
            legal_o = 1'b0;
            count_o = '0;
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes, checks legality and ring continuity, locks after LOCK_CNT matches.
// Optional saturating error counter enabled by defining JOHNSON_ERR_COUNT_EN.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 2,
    localparam int CW       = cnt_w(N),
    localparam int TW       = 2 * N
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  code_in,
    input  logic          code_valid,
    output logic [CW-1:0] bin_out,
    output logic [TW-1:0] onehot_out,
    output logic          out_valid,
    output logic          illegal,
    output logic          seq_err,
    output logic          locked,
    output logic [7:0]    err_count
);

    state_e            state_q, state_d;
    logic [LOCK_W-1:0] match_q, match_d, match_inc_s;
    logic [CW-1:0]     last_q, last_d, succ_s;
    logic [CW-1:0]     bin_q, bin_d;
    logic [TW-1:0]     onehot_q, onehot_d;
    logic              out_valid_q, illegal_q, illegal_d, seq_err_q, seq_err_d, locked_q;
    logic              legal_s;
    logic [CW-1:0]     count_s;

    johnson_code_check #(.N(N)) u_check (
        .code_i  (code_in),
        .legal_o (legal_s),
        .count_o (count_s)
    );

    // Next-state: decode outputs, SEARCH/TRACK transitions, match counting and last-code tracking.
    always_comb begin
        succ_s      = (last_q == CW'(TW - 1)) ? '0 : (last_q + CW'(1));
        match_inc_s = (match_q == {LOCK_W{1'b1}}) ? match_q : (match_q + LOCK_W'(1));
        state_d     = state_q;
        match_d     = match_q;
        last_d      = last_q;
        bin_d       = bin_q;
        onehot_d    = onehot_q;
        illegal_d   = 1'b0;
        seq_err_d   = 1'b0;
        if (code_valid) begin
            bin_d = count_s;
            if (!legal_s) begin
                onehot_d  = '0;
                illegal_d = 1'b1;
                match_d   = '0;
                state_d   = SEARCH;
            end else begin
                onehot_d = TW'(1) << count_s;
                last_d   = count_s;
                case (state_q)
                    TRACK: begin
                        if (count_s != succ_s) begin
                            seq_err_d = 1'b1;
                            match_d   = LOCK_W'(1);
                            state_d   = SEARCH;
                        end else begin
                            state_d   = TRACK;
                        end
                    end
                    SEARCH: begin
                        match_d = (count_s == succ_s) ? match_inc_s : LOCK_W'(1);
                        if (match_d >= LOCK_W'(LOCK_CNT)) begin
                            state_d = TRACK;
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                    default: begin
                        match_d = '0;
                        state_d = SEARCH;
                    end
                endcase
            end
        end else begin
            onehot_d = onehot_q;
        end
    end

    // State and registered outputs; locked reflects the FSM state one cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SEARCH;
            match_q     <= '0;
            last_q      <= '0;
            bin_q       <= '0;
            onehot_q    <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            last_q      <= last_d;
            bin_q       <= bin_d;
            onehot_q    <= onehot_d;
            out_valid_q <= code_valid;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            locked_q    <= (state_q == TRACK);
        end
    end

`ifdef JOHNSON_ERR_COUNT_EN
    logic [7:0] err_q;

    // Saturating count of flagged samples, updated alongside illegal/seq_err.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 8'd0;
        end else if ((illegal_d || seq_err_d) && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end else begin
            err_q <= err_q;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

    assign bin_out    = bin_q;
    assign onehot_out = onehot_q;
    assign out_valid  = out_valid_q;
    assign illegal    = illegal_q;
    assign seq_err    = seq_err_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed self-checking bench for johnson_decoder (N=4, LOCK_CNT=2).
// Error-counter expectations follow JOHNSON_ERR_COUNT_EN.
module tb_johnson_decoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] code_in = 4'd0;
    logic       code_valid = 1'b0;
    logic [2:0] bin_out;
    logic [7:0] onehot_out;
    logic       out_valid, illegal, seq_err, locked;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    johnson_decoder dut (
        .clock      (clock),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .bin_out    (bin_out),
        .onehot_out (onehot_out),
        .out_valid  (out_valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic v, input logic r);
        @(negedge clock);
        code_in    = c;
        code_valid = v;
        reset      = r;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] b, input logic [7:0] oh,
                           input logic ov, input logic il, input logic se, input logic lk);
        chk({tag, ".bin"},     32'(bin_out),    32'(b));
        chk({tag, ".onehot"},  32'(onehot_out), 32'(oh));
        chk({tag, ".valid"},   32'(out_valid),  32'(ov));
        chk({tag, ".illegal"}, 32'(illegal),    32'(il));
        chk({tag, ".seq_err"}, 32'(seq_err),    32'(se));
        chk({tag, ".locked"},  32'(locked),     32'(lk));
    endtask

    logic [3:0] ring_codes [9];
    logic [2:0] ring_bins  [9];
    logic [7:0] exp_err;

    initial begin
        ring_codes = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        ring_bins  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

        // Reset state
        step(4'b0000, 1'b0, 1'b1);
        chk_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.err", 32'(err_count), 32'd0);

        // Full ring including 7->0 wrap; locked from the third sample
        for (int i = 0; i < 9; i++) begin
            step(ring_codes[i], 1'b1, 1'b0);
            chk_all($sformatf("ring%0d", i), ring_bins[i], 8'h01 << ring_bins[i],
                    1'b1, 1'b0, 1'b0, (i >= 2));
        end

        // Illegal injection while locked, then relock
        step(4'b0011, 1'b1, 1'b0);
        chk_all("pre_ill", 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1);
        step(4'b0101, 1'b1, 1'b0);
        chk_all("ill", 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        step(4'b0111, 1'b1, 1'b0);
        chk_all("ill_drop", 3'd3, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        chk_all("ill_m2", 3'd4, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b1110, 1'b1, 1'b0);
        chk_all("ill_relock", 3'd5, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);

        // Walk round to 0111 while locked, then skip to 1100
        step(4'b1100, 1'b1, 1'b0);
        step(4'b1000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        chk_all("pre_skip", 3'd3, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1);
        step(4'b1100, 1'b1, 1'b0);
        chk_all("skip", 3'd6, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1);
        step(4'b1000, 1'b1, 1'b0);
        chk_all("skip_search", 3'd7, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk_all("skip_relock", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef JOHNSON_ERR_COUNT_EN
        exp_err = 8'd2;
`else
        exp_err = 8'd0;
`endif
        chk("err_after_two", 32'(err_count), 32'(exp_err));

        // Reset together with a valid sample mid-TRACK
        step(4'b0001, 1'b1, 1'b1);
        chk_all("rst_mid", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid.err", 32'(err_count), 32'd0);

        // Valid gaps: outputs hold, continuity preserved across the gap
        step(4'b0001, 1'b1, 1'b0);
        chk_all("gap_first", 3'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0101, 1'b0, 1'b0);
            chk_all($sformatf("gap_idle%0d", i), 3'd1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(4'b0011, 1'b1, 1'b0);
        chk_all("gap_next", 3'd2, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk_all("gap_lock", 3'd2, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);

        // 300 alternating illegal codes from a cleared counter
        step(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1, 1'b0);
            if (i == 0 || i == 299) begin
                chk($sformatf("sat_ill%0d", i), 32'(illegal), 32'd1);
            end
            if (i == 253) begin
`ifdef JOHNSON_ERR_COUNT_EN
                exp_err = 8'd254;
`else
                exp_err = 8'd0;
`endif
                chk("err_254", 32'(err_count), 32'(exp_err));
            end
        end
`ifdef JOHNSON_ERR_COUNT_EN
        exp_err = 8'd255;
`else
        exp_err = 8'd0;
`endif
        chk("err_sat", 32'(err_count), 32'(exp_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
